sum_window_accum: RTL and testbench

Downstream consumer of the registered 8-bit adder stage. It accumulates a fixed window of sum samples and reports the window total, maximum, minimum and an overflow flag through a valid/ready output handshake. An output holding register lets the next window fill while the previous result waits. Input backpressure is applied only when a completed window cannot be handed off.

---
 rtl/sum_window_accum_pkg.sv | 32 +++
 rtl/sum_window_accum_if.sv | 29 ++
 rtl/sum_window_accum_minmax_track.sv | 32 +++
 rtl/sum_window_accum.sv | 105 ++++++++++
 tb/tb_sum_window_accum.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sum_window_accum_pkg.sv
// Shared defaults and saturating-add helper for the window accumulator.
package sum_accum_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WINDOW_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W      = $clog2(WINDOW_DEF);

  typedef struct packed {
    logic        ovf;
    logic [31:0] sum;
  } sat_t;

  // Adds at one bit wider than the operands and clamps to 2^w - 1 (w < 32).
  function automatic sat_t sat_add(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    sat_t        r;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (s > lim) begin
      r.ovf = 1'b1;
      r.sum = lim[31:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = s[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_window_accum_if.sv
// Sample input and window-result output handshakes of the accumulator.
interface sum_window_accum_if
  import sum_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic              out_ovf;

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_min, out_ovf
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_min, out_ovf
  );
endinterface

// File: rtl/sum_window_accum_minmax_track.sv
// Running max/min of the current window; exposes values including the current sample.
module minmax_track #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] mx_nxt_o,
  output logic [DATA_W-1:0] mn_nxt_o
);
  logic [DATA_W-1:0] mx_q;
  logic [DATA_W-1:0] mn_q;

  // Candidate extremes if data_i is folded into the window.
  always_comb begin
    mx_nxt_o = (data_i > mx_q) ? data_i : mx_q;
    mn_nxt_o = (data_i < mn_q) ? data_i : mn_q;
  end

  // Track extremes; clear restarts the window with identity values.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      mx_q <= '0;
      mn_q <= '1;
    end else if (upd_i) begin
      mx_q <= mx_nxt_o;
      mn_q <= mn_nxt_o;
    end
  end
endmodule

// File: rtl/sum_window_accum.sv
// Window accumulator: sum/max/min/overflow per WINDOW samples, with output holding register.
module sum_window_accum
  import sum_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input logic clk,
  input logic reset,
  sum_window_accum_if.slave bus
);
  localparam int             CW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WINDOW - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              ovalid_q, ovalid_d;
  logic [ACC_W-1:0]  osum_q, osum_d;
  logic [DATA_W-1:0] omax_q, omax_d;
  logic [DATA_W-1:0] omin_q, omin_d;
  logic              oovf_q, oovf_d;

  logic              is_last, rdy, beat, hs;
  logic [DATA_W-1:0] mx_nxt, mn_nxt;
  sat_t              sat;

  assign is_last = (cnt_q == LAST);
  // Stall only when the final beat would overwrite a result still pending;
  // depends on registered state only.
  assign rdy     = !(ovalid_q && is_last);
  assign beat    = bus.in_valid && rdy;
  assign hs      = ovalid_q && bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovalid_q;
  assign bus.out_sum   = osum_q;
  assign bus.out_max   = omax_q;
  assign bus.out_min   = omin_q;
  assign bus.out_ovf   = oovf_q;

  minmax_track #(.DATA_W(DATA_W)) u_minmax (
    .clk      (clk),
    .reset    (reset),
    .upd_i    (beat && !is_last),
    .clr_i    (beat && is_last),
    .data_i   (bus.in_data),
    .mx_nxt_o (mx_nxt),
    .mn_nxt_o (mn_nxt)
  );

  // Next-state: accumulate on non-final beats, publish and restart on the final beat.
  always_comb begin
    sat      = sat_add(32'(acc_q), 32'(bus.in_data), ACC_W);
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    ovalid_d = ovalid_q;
    osum_d   = osum_q;
    omax_d   = omax_q;
    omin_d   = omin_q;
    oovf_d   = oovf_q;
    if (hs) ovalid_d = 1'b0;
    if (beat) begin
      if (is_last) begin
        cnt_d    = '0;
        acc_d    = '0;
        ovf_d    = 1'b0;
        ovalid_d = 1'b1;
        osum_d   = sat.sum[ACC_W-1:0];
        omax_d   = mx_nxt;
        omin_d   = mn_nxt;
        oovf_d   = ovf_q | sat.ovf;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sat.sum[ACC_W-1:0];
        ovf_d = ovf_q | sat.ovf;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
      osum_q   <= '0;
      omax_q   <= '0;
      omin_q   <= '0;
      oovf_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      ovalid_q <= ovalid_d;
      osum_q   <= osum_d;
      omax_q   <= omax_d;
      omin_q   <= omin_d;
      oovf_q   <= oovf_d;
    end
  end
endmodule

// File: tb/tb_sum_window_accum.sv
// Bench: two accumulators (ACC_W 16 and 10) on shared stimulus vs. a window-level model.
module tb_sum_window_accum;
  import sum_accum_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  always #5 clk = ~clk;

  sum_window_accum_if #(.DATA_W(8), .ACC_W(16)) ifa ();
  sum_window_accum_if #(.DATA_W(8), .ACC_W(10)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  sum_window_accum #(.DATA_W(8), .WINDOW(W), .ACC_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  sum_window_accum #(.DATA_W(8), .WINDOW(W), .ACC_W(10)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: list of accepted samples in the open window and the published result.
  int   win[$];
  bit   pending;
  int   e_sum16, e_sum10, e_mx, e_mn;
  bit   e_ovf16, e_ovf10;
  bit   last_beat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    win.delete();
    pending = 0;
    e_sum16 = 0; e_sum10 = 0; e_mx = 0; e_mn = 0;
    e_ovf16 = 0; e_ovf10 = 0;
  endtask

  task automatic publish();
    int total, mx, mn;
    total = 0; mx = 0; mn = 255;
    foreach (win[k]) begin
      total += win[k];
      if (win[k] > mx) mx = win[k];
      if (win[k] < mn) mn = win[k];
    end
    e_sum16 = (total > 65535) ? 65535 : total;
    e_ovf16 = (total > 65535);
    e_sum10 = (total > 1023) ? 1023 : total;
    e_ovf10 = (total > 1023);
    e_mx = mx;
    e_mn = mn;
    pending = 1;
    win.delete();
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then cross the edge.
  task automatic step();
    bit exp_rdy, beat, hs;
    @(negedge clk);
    last_beat = 0;
    if (reset) begin
      model_clear();
    end else begin
      exp_rdy = !(pending && win.size() == W - 1);
      chk("a_in_ready",  32'(ifa.in_ready),  32'(exp_rdy));
      chk("b_in_ready",  32'(ifb.in_ready),  32'(exp_rdy));
      chk("a_out_valid", 32'(ifa.out_valid), 32'(pending));
      chk("b_out_valid", 32'(ifb.out_valid), 32'(pending));
      chk("a_out_sum",   32'(ifa.out_sum),   32'(e_sum16));
      chk("b_out_sum",   32'(ifb.out_sum),   32'(e_sum10));
      chk("a_out_ovf",   32'(ifa.out_ovf),   32'(e_ovf16));
      chk("b_out_ovf",   32'(ifb.out_ovf),   32'(e_ovf10));
      chk("a_out_max",   32'(ifa.out_max),   32'(e_mx));
      chk("b_out_max",   32'(ifb.out_max),   32'(e_mx));
      chk("a_out_min",   32'(ifa.out_min),   32'(e_mn));
      chk("b_out_min",   32'(ifb.out_min),   32'(e_mn));
      beat = in_valid && exp_rdy;
      hs   = pending && out_ready;
      if (hs) pending = 0;
      if (beat) begin
        last_beat = 1;
        win.push_back(int'(in_data));
        if (win.size() == W) publish();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_clear();
    last_beat = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held two cycles with a sample offered; nothing may be counted.
    step();
    step();
    reset = 1'b0;
    idle(2);

    // Basic window 1..8; result visible exactly one cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(i);
    idle(3);

    // Backpressure: result A pending while window B fills.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3);
    for (int i = 0; i < 7; i++) send(10);
    send(10);
    send(10);
    out_ready = 1'b1;
    send(10);
    out_ready = 1'b0;
    send(10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Saturation on the narrow accumulator, then a clean zero window.
    for (int i = 0; i < 8; i++) send(255);
    for (int i = 0; i < 8; i++) send(0);
    idle(2);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 5; i++) send(9);
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send(2);
    idle(2);

    // Bubbles on alternate cycles.
    for (int i = 1; i <= 8; i++) begin
      send(i);
      idle(1);
    end
    idle(1);

    // Handshake landing on the stall cycle, final beat right after.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i + 20);
    for (int i = 0; i < 7; i++) send(i + 40);
    out_ready = 1'b1;
    send(47);
    send(47);
    in_valid = 1'b0;
    idle(3);

    // Random traffic; upstream holds its sample until accepted.
    in_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!in_valid || last_beat) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    out_ready = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
